// File: rtl/instr_fetch_pkg.sv
// Package fetch_pkg: shared types and constants for the instruction fetch unit.
//   fetch_state_t : IDLE / RUN / HALT sequencing states
//   HALT_INSTR    : instruction word that stops execution
//   *_DEF         : default widths (PC, instruction, jump-LUT index)
//   JUMP_LUT      : absolute jump targets, indexed by JumpIdx
package fetch_pkg;

    localparam int PC_W_DEF      = 8;
    localparam int INSTR_W_DEF   = 9;
    localparam int LUT_IDX_W_DEF = 4;

    localparam logic [INSTR_W_DEF-1:0] HALT_INSTR = 9'h1FF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [PC_W_DEF-1:0] JUMP_LUT [2**LUT_IDX_W_DEF] = '{
        8'h00, 8'h18, 8'h2C, 8'h47, 8'h55, 8'h60, 8'h6A, 8'h7F,
        8'h80, 8'h93, 8'hA0, 8'hB4, 8'hC8, 8'hD0, 8'hE6, 8'hF8
    };

endpackage

// File: rtl/instr_fetch_if.sv
// Interface instr_fetch_if: control and ROM signals between the fetch unit
// (master) and its surroundings: sequencer, branch/jump logic, InstrROM,
// decode (slave).
//   slave -> master : Start, StartAddr, Stall, BranchTaken, BranchOffset,
//                     JumpEn, JumpIdx, InstrOut
//   master -> slave : InstrAddress, Instr, InstrValid, Done
interface instr_fetch_if
    import fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int LUT_IDX_W = LUT_IDX_W_DEF
);
    logic                 Start;
    logic [PC_W-1:0]      StartAddr;
    logic                 Stall;
    logic                 BranchTaken;
    logic [PC_W-1:0]      BranchOffset;
    logic                 JumpEn;
    logic [LUT_IDX_W-1:0] JumpIdx;
    logic [INSTR_W-1:0]   InstrOut;
    logic [PC_W-1:0]      InstrAddress;
    logic [INSTR_W-1:0]   Instr;
    logic                 InstrValid;
    logic                 Done;

    modport master (
        input  Start, StartAddr, Stall, BranchTaken, BranchOffset,
               JumpEn, JumpIdx, InstrOut,
        output InstrAddress, Instr, InstrValid, Done
    );

    modport slave (
        output Start, StartAddr, Stall, BranchTaken, BranchOffset,
               JumpEn, JumpIdx, InstrOut,
        input  InstrAddress, Instr, InstrValid, Done
    );
endinterface

// File: rtl/instr_fetch_jump_lut.sv
// Module jump_lut: combinational jump-target table.
//   jumpIdx in  LUT_IDX_W  table index
//   target  out PC_W       absolute PC for the jump
module jump_lut
    import fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
    input  logic [LUT_IDX_W-1:0] jumpIdx,
    output logic [PC_W-1:0]      target
);
    assign target = PC_W'(JUMP_LUT[jumpIdx]);
endmodule

// File: rtl/instr_fetch.sv
// Module instr_fetch: program counter / fetch sequencer.
//   Clk        in   rising-edge clock
//   Reset_n    in   asynchronous active-low reset
//   bus        master modport of instr_fetch_if (start, flow control,
//              ROM address/data, decoded-instruction output, Done)
//   CycleCount out  16-bit RUN-cycle counter, present only when the
//              FETCH_CYCLE_COUNT_EN macro is defined
// Start restarts from any state. In RUN, Stall holds everything. Otherwise
// halt > jump > branch > increment. The ROM is combinational, so Instr follows
// InstrAddress in the same cycle.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    instr_fetch_if.master    bus
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    output logic [15:0]      CycleCount
`endif
);
    fetch_state_t    stateQ, stateD;
    logic [PC_W-1:0] pcQ, pcD;
    logic [PC_W-1:0] jumpTarget;
    logic            isHalt;

    jump_lut #(.PC_W(PC_W), .LUT_IDX_W(LUT_IDX_W)) uLut (
        .jumpIdx (bus.JumpIdx),
        .target  (jumpTarget)
    );

    assign isHalt = (bus.InstrOut == INSTR_W'(HALT_INSTR));

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) stateQ <= IDLE;
        else          stateQ <= stateD;
    end

    // Next state
    always_comb begin
        stateD = stateQ;
        if (bus.Start)
            stateD = RUN;
        else if (stateQ == RUN && !bus.Stall && isHalt)
            stateD = HALT;
    end

    // Outputs
    always_comb begin
        bus.InstrAddress = pcQ;
        bus.InstrValid   = (stateQ == RUN);
        bus.Done         = (stateQ == HALT);
        bus.Instr        = (stateQ == RUN) ? bus.InstrOut : '0;
    end

    // Next PC. The branch add is done at PC width, so a two's-complement
    // offset sign-extends for free and the sum wraps mod 2**PC_W.
    always_comb begin
        pcD = pcQ;
        if (bus.Start)
            pcD = bus.StartAddr;
        else if (stateQ == RUN && !bus.Stall && !isHalt) begin
            if (bus.JumpEn)
                pcD = jumpTarget;
            else if (bus.BranchTaken)
                pcD = pcQ + bus.BranchOffset;
            else
                pcD = pcQ + PC_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) pcQ <= '0;
        else          pcQ <= pcD;
    end

`ifdef FETCH_CYCLE_COUNT_EN
    // Counts every edge spent in RUN, stalls included, plus the edge that halts.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            CycleCount <= '0;
        else if (bus.Start)
            CycleCount <= '0;
        else if (stateQ == RUN && CycleCount != 16'hFFFF)
            CycleCount <= CycleCount + 16'd1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. The ROM model returns {1'b0, addr}, except
// at haltAddr when haltEn is set, where it returns the halt word.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    logic haltEn = 1'b0;
    logic [7:0] haltAddr = 8'h00;
    int nChk = 0;
    int nBad = 0;

    always #5 Clk = ~Clk;

    instr_fetch_if bus ();

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycleCount;
`endif

    instr_fetch dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
`ifdef FETCH_CYCLE_COUNT_EN
        ,
        .CycleCount (cycleCount)
`endif
    );

    assign bus.InstrOut = (haltEn && bus.InstrAddress == haltAddr) ? 9'h1FF
                                                                   : {1'b0, bus.InstrAddress};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clearCtl();
        bus.Start        = 1'b0;
        bus.StartAddr    = '0;
        bus.Stall        = 1'b0;
        bus.BranchTaken  = 1'b0;
        bus.BranchOffset = '0;
        bus.JumpEn       = 1'b0;
        bus.JumpIdx      = '0;
    endtask

    task automatic startAt(input logic [7:0] a);
        bus.Start     = 1'b1;
        bus.StartAddr = a;
        tick();
        bus.Start     = 1'b0;
    endtask

    initial begin
        clearCtl();
        #12;
        check("rst_addr",  32'(bus.InstrAddress), 32'h00);
        check("rst_valid", 32'(bus.InstrValid),   32'h0);
        check("rst_done",  32'(bus.Done),         32'h0);
        check("rst_instr", 32'(bus.Instr),        32'h000);
`ifdef FETCH_CYCLE_COUNT_EN
        check("rst_cnt",   32'(cycleCount),       32'h0);
`endif
        @(negedge Clk);
        Reset_n = 1'b1;

        // IDLE ignores flow control
        bus.Stall = 1'b0; bus.JumpEn = 1'b1; bus.JumpIdx = 4'd3;
        tick();
        check("idle_addr",  32'(bus.InstrAddress), 32'h00);
        check("idle_valid", 32'(bus.InstrValid),   32'h0);
        clearCtl();

        // start and sequential increment
        startAt(8'h10);
        check("start_addr",  32'(bus.InstrAddress), 32'h10);
        check("start_valid", 32'(bus.InstrValid),   32'h1);
        check("start_instr", 32'(bus.Instr),        32'h010);
        tick();
        check("inc_11", 32'(bus.InstrAddress), 32'h11);
        tick();
        check("inc_12", 32'(bus.InstrAddress), 32'h12);

        // negative branch 0x20 + 0xF0 -> 0x10
        startAt(8'h20);
        bus.BranchTaken = 1'b1; bus.BranchOffset = 8'hF0;
        tick();
        check("branch_neg", 32'(bus.InstrAddress), 32'h10);
        bus.BranchOffset = 8'h05;
        tick();
        check("branch_pos", 32'(bus.InstrAddress), 32'h15);
        clearCtl();

        // increment wraps
        startAt(8'hFF);
        check("at_ff", 32'(bus.InstrAddress), 32'hFF);
        tick();
        check("wrap_00", 32'(bus.InstrAddress), 32'h00);

        // jump beats branch; LUT[3] = 0x47
        bus.JumpEn = 1'b1; bus.JumpIdx = 4'd3;
        bus.BranchTaken = 1'b1; bus.BranchOffset = 8'h02;
        tick();
        check("jump_lut3", 32'(bus.InstrAddress), 32'h47);

        // stall holds the PC even with jump/branch asserted
        bus.Stall = 1'b1; bus.JumpIdx = 4'd9;
        tick();
        check("stall_hold",  32'(bus.InstrAddress), 32'h47);
        check("stall_valid", 32'(bus.InstrValid),   32'h1);
        bus.Stall = 1'b0;
        tick();
        check("jump_lut9", 32'(bus.InstrAddress), 32'h93);
        clearCtl();

        // halt at 0x05 beats a same-cycle branch
        haltEn = 1'b1; haltAddr = 8'h05;
        startAt(8'h05);
        check("halt_instr", 32'(bus.Instr), 32'h1FF);
        bus.BranchTaken = 1'b1; bus.BranchOffset = 8'h10;
        tick();
        check("halt_done",  32'(bus.Done),         32'h1);
        check("halt_valid", 32'(bus.InstrValid),   32'h0);
        check("halt_addr",  32'(bus.InstrAddress), 32'h05);
        check("halt_instr0", 32'(bus.Instr),       32'h000);
        tick();
        check("halt_held",  32'(bus.InstrAddress), 32'h05);
        check("halt_done2", 32'(bus.Done),         32'h1);
        clearCtl();
        haltEn = 1'b0;

        // Start beats Stall when leaving HALT
        bus.Stall = 1'b1;
        startAt(8'h30);
        check("restart_done",  32'(bus.Done),         32'h0);
        check("restart_valid", 32'(bus.InstrValid),   32'h1);
        check("restart_addr",  32'(bus.InstrAddress), 32'h30);
        clearCtl();

        // asynchronous reset in the middle of RUN
        startAt(8'h23);
        check("pre_rst_addr", 32'(bus.InstrAddress), 32'h23);
        #2;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_addr",  32'(bus.InstrAddress), 32'h00);
        check("mid_rst_valid", 32'(bus.InstrValid),   32'h0);
        check("mid_rst_done",  32'(bus.Done),         32'h0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(bus.InstrValid), 32'h0);

`ifdef FETCH_CYCLE_COUNT_EN
        // 7 edges in RUN (2 stalled), halt on the 7th
        haltEn = 1'b1; haltAddr = 8'h44;
        startAt(8'h40);
        check("cnt_clear", 32'(cycleCount), 32'h0);
        tick(); tick();
        bus.Stall = 1'b1;
        tick(); tick();
        bus.Stall = 1'b0;
        tick(); tick(); tick();
        check("cnt_halt_done", 32'(bus.Done), 32'h1);
        check("cnt_seven",     32'(cycleCount), 32'h7);
        tick(); tick();
        check("cnt_frozen",    32'(cycleCount), 32'h7);
        haltEn = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", nChk, nBad);
        $finish;
    end
endmodule
